// File: rtl/freq_meter_pkg.sv
// ==== freq_meter_pkg : shared types and constants for the frequency meter ====
// ==== rev 1.0                                                              ====
`default_nettype none

package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_GATE   = 2'd2,
    ST_REPORT = 2'd3
  } fm_state_e;

  localparam int GATE_W     = 18;
  localparam int ARM_CYCLES = 2;

  // One millisecond expressed in system clock cycles.
  function automatic int unsigned gate_len(input int unsigned f);
    return f * 1000;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sig_sync_edge.sv
// ==== sig_sync_edge : 3-flop synchronizer with rising-edge detect ====
// ==== rev 1.0                                                    ====
`default_nettype none

module sig_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic level,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;

endmodule

`default_nettype wire

// File: rtl/freq_meter.sv
// ==== freq_meter : counts edges and high time of sig_in over a 1 ms gate ====
// ==== rev 1.0                                                            ====
`default_nettype none

module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned freq  = 40,
  parameter int          CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sig_in,
  output logic              busy,
  output logic              valid,
  output logic [CNT_W-1:0]  edge_count,
  output logic [GATE_W-1:0] high_cycles,
  output logic              overflow
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_ARM    = ST_ARM;
  localparam logic [1:0] S_GATE   = ST_GATE;
  localparam logic [1:0] S_REPORT = ST_REPORT;

  localparam int unsigned         GATE_LEN  = gate_len(freq);
  localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_LEN - 1);
  localparam logic [CNT_W-1:0]    EDGE_MAX  = '1;
  localparam int                  ARM_W     = $clog2(ARM_CYCLES);
  localparam logic [ARM_W-1:0]    ARM_LAST  = ARM_W'(ARM_CYCLES - 1);

  if (freq < 12 || freq > 140) begin : g_freq_range
    $error("freq_meter: freq=%0d outside 12..140", freq);
  end

  logic sig_level, sig_rise;

  sig_sync_edge u_sync (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .level  (sig_level),
    .rise   (sig_rise)
  );

  logic [1:0]        state_q,      state_d;
  logic [ARM_W-1:0]  arm_cnt_q,    arm_cnt_d;
  logic [GATE_W-1:0] gate_cnt_q,   gate_cnt_d;
  logic [CNT_W-1:0]  edge_acc_q,   edge_acc_d;
  logic [GATE_W-1:0] high_acc_q,   high_acc_d;
  logic              ovf_acc_q,    ovf_acc_d;
  logic [CNT_W-1:0]  edge_out_q,   edge_out_d;
  logic [GATE_W-1:0] high_out_q,   high_out_d;
  logic              ovf_out_q,    ovf_out_d;

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    gate_cnt_d = gate_cnt_q;
    edge_acc_d = edge_acc_q;
    high_acc_d = high_acc_q;
    ovf_acc_d  = ovf_acc_q;
    edge_out_d = edge_out_q;
    high_out_d = high_out_q;
    ovf_out_d  = ovf_out_q;

    case (state_q)
      S_IDLE: begin
        arm_cnt_d  = '0;
        gate_cnt_d = '0;
        edge_acc_d = '0;
        high_acc_d = '0;
        ovf_acc_d  = 1'b0;
        if (enable) state_d = S_ARM;
      end
      S_ARM: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (arm_cnt_q == ARM_LAST) begin
          state_d    = S_GATE;
          arm_cnt_d  = '0;
          gate_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      S_GATE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          if (sig_rise) begin
            if (edge_acc_q == EDGE_MAX) ovf_acc_d  = 1'b1;
            else                        edge_acc_d = edge_acc_q + 1'b1;
          end
          if (sig_level) high_acc_d = high_acc_q + 1'b1;

          // Results are registered on entry to REPORT so they are visible alongside valid.
          if (gate_cnt_q == GATE_LAST) begin
            state_d    = S_REPORT;
            gate_cnt_d = '0;
            edge_out_d = edge_acc_d;
            high_out_d = high_acc_d;
            ovf_out_d  = ovf_acc_d;
            edge_acc_d = '0;
            high_acc_d = '0;
            ovf_acc_d  = 1'b0;
          end else begin
            gate_cnt_d = gate_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        gate_cnt_d = '0;
        state_d    = enable ? S_GATE : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      arm_cnt_q  <= '0;
      gate_cnt_q <= '0;
      edge_acc_q <= '0;
      high_acc_q <= '0;
      ovf_acc_q  <= 1'b0;
      edge_out_q <= '0;
      high_out_q <= '0;
      ovf_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      edge_acc_q <= edge_acc_d;
      high_acc_q <= high_acc_d;
      ovf_acc_q  <= ovf_acc_d;
      edge_out_q <= edge_out_d;
      high_out_q <= high_out_d;
      ovf_out_q  <= ovf_out_d;
    end
  end

  assign busy        = (state_q == S_ARM) || (state_q == S_GATE);
  assign valid       = (state_q == S_REPORT);
  assign edge_count  = edge_out_q;
  assign high_cycles = high_out_q;
  assign overflow    = ovf_out_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_meter.sv
// ==== tb_freq_meter : randomized-phase checks of freq_meter against a trace model ====
// ==== rev 1.0                                                                     ====
`default_nettype none

module tb_freq_meter;

  localparam int G      = 12000;
  localparam int HIST_N = 100000;

  logic        clk = 1'b0;
  logic        reset, enable, sig_in;
  logic        busy16, valid16, ov16;
  logic [15:0] ec16;
  logic [17:0] hc16;
  logic        busy10, valid10, ov10;
  logic [9:0]  ec10;
  logic [17:0] hc10;

  freq_meter #(.freq(12), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .busy(busy16), .valid(valid16), .edge_count(ec16),
    .high_cycles(hc16), .overflow(ov16)
  );

  freq_meter #(.freq(12), .CNT_W(10)) dut10 (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .busy(busy10), .valid(valid10), .edge_count(ec10),
    .high_cycles(hc10), .overflow(ov10)
  );

  always #5 clk = ~clk;

  // hist[n] is the sig_in value driven during cycle n.
  int cyc = 0;
  bit hist [HIST_N];
  always @(posedge clk) begin
    if (cyc < HIST_N) hist[cyc] <= sig_in;
    cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  int mode = 0, cval = 0, per_v = 12, hi_v = 6, org = 0;

  function automatic logic wave();
    if (mode == 0) return cval[0];
    return ((cyc - org) % per_v) < hi_v;
  endfunction

  task automatic step();
    @(negedge clk);
    sig_in = wave();
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic set_square(input int p, input int h);
    mode = 1; per_v = p; hi_v = h; org = cyc;
    sig_in = wave();
  endtask

  task automatic set_const(input int v);
    mode = 0; cval = v;
    sig_in = wave();
  endtask

  // Expected report for the gate whose first cycle is s: the synchronized level in
  // cycle k is the input driven two cycles earlier.
  task automatic model(input int s, input int cw, output int e, output int h, output int o);
    int raw, mx;
    raw = 0; h = 0;
    for (int k = s; k < s + G; k++) begin
      if (hist[k-2]) h++;
      if (hist[k-2] && !hist[k-3]) raw++;
    end
    mx = (1 << cw) - 1;
    e  = (raw > mx) ? mx : raw;
    o  = (raw > mx) ? 1 : 0;
  endtask

  task automatic check_report(input string tag, input int s);
    int e, h, o;
    chk({tag, "_at"}, cyc, s + G);
    model(s, 16, e, h, o);
    chk({tag, "_edges16"}, ec16, e);
    chk({tag, "_high16"},  hc16, h);
    chk({tag, "_ovf16"},   ov16, o);
    model(s, 10, e, h, o);
    chk({tag, "_edges10"}, ec10, e);
    chk({tag, "_high10"},  hc10, h);
    chk({tag, "_ovf10"},   ov10, o);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (valid16) found = 1'b1;
    end
    if (!found) chk({tag, "_timeout"}, 0, 1);
    else        chk({tag, "_valid10"}, valid10, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t, s, r_prev, nv;

  initial begin
    reset = 1'b1; enable = 1'b0;
    set_const(1);
    repeat (2 + $urandom_range(0, 3)) step();
    chk("rst_busy",  busy16, 0);
    chk("rst_valid", valid16, 0);
    chk("rst_edges", ec16, 0);
    chk("rst_high",  hc16, 0);
    chk("rst_ovf",   ov16, 0);
    chk("rst_busy10", busy10, 0);

    // sig_in high through reset, enable on the first cycle after release
    reset = 1'b0;
    step();
    enable = 1'b1; t = cyc; s = t + 3;
    step_to(s + G - 2);
    set_square(12, 6);
    wait_valid("s2", 20);
    check_report("s2", s);
    chk("s2_edges", ec16, 0);
    chk("s2_high",  hc16, G);

    // continuous square wave at clk/12
    r_prev = cyc; s = s + G + 1;
    wait_valid("s1", G + 10);
    check_report("s1", s);
    chk("s1_edges",  ec16, 1000);
    chk("s1_high",   hc16, 6000);
    chk("s1_ovf",    ov16, 0);
    chk("s1_period", cyc - r_prev, G + 1);

    // enable dropped mid-gate
    s = s + G + 1;
    step_to(s + 5000);
    chk("s4_busy_pre", busy16, 1);
    enable = 1'b0;
    step();
    chk("s4_busy",  busy16, 0);
    chk("s4_edges", ec16, 1000);
    chk("s4_high",  hc16, 6000);
    chk("s4_ovf",   ov16, 0);
    nv = 0;
    repeat (200 + $urandom_range(0, 100)) begin
      step();
      if (valid16 || valid10 || busy16) nv++;
    end
    chk("s4_quiet", nv, 0);
    chk("s4_hold_edges", ec16, 1000);

    // clk/4 input saturates the 10-bit counter
    set_square(4, 2);
    repeat ($urandom_range(0, 3)) step();
    enable = 1'b1; t = cyc; s = t + 3;
    step_to(s + G - 1);
    set_const(0);
    wait_valid("s3", 20);
    check_report("s3", s);
    chk("s3_sat10",   ec10, 1023);
    chk("s3_ovf10",   ov10, 1);
    chk("s3_edges16", ec16, 3000);
    chk("s3_high10",  hc10, 6000);
    s = s + G + 1;
    wait_valid("s3z", G + 10);
    check_report("s3z", s);
    chk("s3z_edges10", ec10, 0);
    chk("s3z_high10",  hc10, 0);
    chk("s3z_ovf10",   ov10, 0);

    // reset mid-gate
    s = s + G + 1;
    step_to(s + 50 + $urandom_range(0, 500));
    reset = 1'b1; enable = 1'b0;
    step();
    reset = 1'b0;
    chk("s5_busy",  busy16, 0);
    chk("s5_valid", valid16, 0);
    chk("s5_edges", ec16, 0);
    chk("s5_high",  hc16, 0);
    chk("s5_ovf",   ov16, 0);
    chk("s5_ovf10", ov10, 0);
    repeat (2 + $urandom_range(0, 4)) step();
    enable = 1'b1; t = cyc; s = t + 3;

    // pulse whose synchronized edge lands in the REPORT cycle
    step_to(s + G - 2);
    sig_in = 1'b1;
    wait_valid("s6a", 20);
    chk("s5_latency", cyc - t, 3 + G);
    check_report("s6a", s);
    chk("s6a_edges", ec16, 0);
    chk("s6a_high",  hc16, 0);

    // pulse whose synchronized edge lands on the last gate cycle
    s = s + G + 1;
    step_to(s + G - 3);
    sig_in = 1'b1;
    wait_valid("s6b", 20);
    check_report("s6b", s);
    chk("s6b_edges", ec16, 1);
    chk("s6b_high",  hc16, 1);

    enable = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
